// File: rtl/perf_mon_sampler.sv
// Periodic snapshot sampler for a bank of static event counters; streams one beat per channel per window.
// Build option: PERF_MON_AUTO_CLEAR_EN makes periodic saves also clear the counters (per-window deltas).
//   state | meaning
//   IDLE  | stopped, waiting for cfg_start_i
//   RUN   | counting; save/final-save commands are issued from here
//   WAIT  | one cycle for counters to present the saved values
//   DRAIN | streaming channel values, idx 0..N_CNT-1
module perf_mon_sampler #(
  parameter int  N_CNT = 4,
  parameter int  CNT_W = 16,
  parameter int  PER_W = 16,
  localparam int IDX_W = (N_CNT > 1) ? $clog2(N_CNT) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   cfg_start_i,
  input  logic                   cfg_stop_i,
  input  logic [PER_W-1:0]       cfg_period_i,
  output logic                   cmd_we_o,
  output logic                   en_o,
  output logic                   clear_o,
  output logic                   save_o,
  input  logic [N_CNT*CNT_W-1:0] cnt_val_i,
  input  logic [N_CNT-1:0]       ovf_i,
  output logic                   out_valid_o,
  output logic [CNT_W-1:0]       out_data_o,
  output logic [IDX_W-1:0]       out_idx_o,
  output logic                   out_ovf_o,
  output logic                   out_last_o,
  input  logic                   out_ready_i,
  output logic                   busy_o,
  output logic                   overrun_o
);

`ifdef PERF_MON_AUTO_CLEAR_EN
  localparam logic PERIODIC_CLEAR = 1'b1;
`else
  localparam logic PERIODIC_CLEAR = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, WAIT, DRAIN} state_t;

  state_t           state_q;
  logic [PER_W-1:0] per_q, ival_q, p_new;
  logic [IDX_W-1:0] idx_q;
  logic [N_CNT-1:0] sticky_q, snap_q;
  logic             stop_lat_q, final_q;
  logic             save_cyc, stop_req, ival_zero, beat_last, go_run;
  logic             issue_final, issue_periodic;
  logic [CNT_W-1:0] sel_data;
  logic             sel_ovf;

  assign p_new     = (cfg_period_i == '0) ? PER_W'(1) : cfg_period_i;
  assign save_cyc  = cmd_we_o & save_o;
  assign stop_req  = stop_lat_q | cfg_stop_i;
  assign ival_zero = (ival_q == '0);
  assign beat_last = (state_q == DRAIN) && out_ready_i && (idx_q == IDX_W'(N_CNT-1));

  // Commands are registered, so the decision is taken one edge early: the
  // command becomes visible in a RUN cycle, which then moves to WAIT.
  assign go_run         = ((state_q == RUN) && !save_cyc) || (beat_last && !final_q);
  assign issue_final    = go_run && stop_req;
  assign issue_periodic = go_run && !stop_req && ival_zero;

  always_comb begin
    sel_data = '0;
    sel_ovf  = 1'b0;
    for (int k = 0; k < N_CNT; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_data = cnt_val_i[k*CNT_W +: CNT_W];
        sel_ovf  = snap_q[k];
      end
    end
  end

  assign out_data_o = out_valid_o ? sel_data : '0;
  assign out_ovf_o  = out_valid_o & sel_ovf;
  assign out_last_o = out_valid_o && (idx_q == IDX_W'(N_CNT-1));
  assign out_idx_o  = idx_q;
  assign busy_o     = (state_q != IDLE);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cmd_we_o    <= 1'b0;
      en_o        <= 1'b0;
      clear_o     <= 1'b0;
      save_o      <= 1'b0;
      out_valid_o <= 1'b0;
      idx_q       <= '0;
      per_q       <= '0;
      ival_q      <= '0;
      sticky_q    <= '0;
      snap_q      <= '0;
      overrun_o   <= 1'b0;
      stop_lat_q  <= 1'b0;
      final_q     <= 1'b0;
    end else begin
      cmd_we_o <= 1'b0;
      en_o     <= 1'b0;
      clear_o  <= 1'b0;
      save_o   <= 1'b0;

      if (state_q != IDLE) begin
        ival_q <= ival_zero ? '0 : ival_q - PER_W'(1);
        if (save_cyc) begin
          snap_q   <= sticky_q | ovf_i;
          sticky_q <= '0;
        end else begin
          sticky_q <= sticky_q | ovf_i;
        end
        if (cfg_stop_i && !final_q) stop_lat_q <= 1'b1;
      end

      if ((state_q == WAIT || state_q == DRAIN) && ival_zero && !final_q)
        overrun_o <= 1'b1;

      case (state_q)
        IDLE: begin
          if (cfg_start_i) begin
            state_q    <= RUN;
            cmd_we_o   <= 1'b1;
            en_o       <= 1'b1;
            clear_o    <= 1'b1;
            per_q      <= p_new;
            ival_q     <= p_new - PER_W'(1);
            overrun_o  <= 1'b0;
            sticky_q   <= '0;
            snap_q     <= '0;
            stop_lat_q <= 1'b0;
            final_q    <= 1'b0;
          end
        end
        RUN: begin
          if (save_cyc) state_q <= WAIT;
        end
        WAIT: begin
          state_q     <= DRAIN;
          idx_q       <= '0;
          out_valid_o <= 1'b1;
        end
        DRAIN: begin
          if (out_ready_i) begin
            if (beat_last) begin
              out_valid_o <= 1'b0;
              idx_q       <= '0;
              if (final_q) begin
                state_q    <= IDLE;
                final_q    <= 1'b0;
                stop_lat_q <= 1'b0;
              end else begin
                state_q <= RUN;
              end
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      // A pending stop outranks a due periodic save; the stop latch is consumed here.
      if (issue_final) begin
        cmd_we_o   <= 1'b1;
        save_o     <= 1'b1;
        final_q    <= 1'b1;
        stop_lat_q <= 1'b0;
      end else if (issue_periodic) begin
        cmd_we_o <= 1'b1;
        en_o     <= 1'b1;
        save_o   <= 1'b1;
        clear_o  <= PERIODIC_CLEAR;
        ival_q   <= per_q - PER_W'(1);
      end
    end
  end

endmodule

// File: doc/perf_mon_sampler.md
PERF_MON_SAMPLER -- requirements
Module: perf_mon_sampler

Interface
REQ-001 SHALL have parameter N_CNT, default 4, the number of attached static counters.
REQ-002 SHALL have parameter CNT_W, default 16, the counter width.
REQ-003 SHALL have parameter PER_W, default 16, the sampling period width.
REQ-004 SHALL have one clock and one asynchronous active-high reset: clk_i  in  1  clock; reset_i  in  1  async active-high reset.
REQ-005 SHALL have inputs cfg_start_i (1, start pulse), cfg_stop_i (1, stop pulse) and cfg_period_i (PER_W, window length in cycles).
REQ-006 SHALL have counter command outputs, broadcast to all counters: cmd_we_o, en_o, clear_o, save_o, each 1 bit.
REQ-007 SHALL have counter inputs cnt_val_i (N_CNT*CNT_W, channel k at bits [k*CNT_W +: CNT_W]) and ovf_i (N_CNT).
REQ-008 SHALL have stream outputs out_valid_o (1), out_data_o (CNT_W), out_idx_o ($clog2(N_CNT)), out_ovf_o (1) and out_last_o (1), plus input out_ready_i (1).
REQ-009 SHALL have status outputs busy_o (1, state != IDLE) and overrun_o (1, sticky deferred-save flag).

Function
REQ-010 SHALL implement states IDLE, RUN, WAIT, DRAIN.
REQ-011 In IDLE, cfg_start_i SHALL issue one command cycle (cmd_we=1, en=1, clear=1, save=0), sample P=max(cfg_period_i,1), load the interval counter with P-1, clear overrun_o and all ovf sticky bits, and go to RUN.
REQ-012 The interval counter SHALL decrement every cycle outside IDLE and hold at 0.
REQ-013 In RUN, when the interval counter is 0, the block SHALL issue a save command (cmd_we=1, en=1, save=1, clear per REQ-024), reload P-1, and go to WAIT; with no deferral, saves occur at t0+P, t0+2P, ...
REQ-014 WAIT SHALL last exactly one cycle, covering the cnt_val_i update latency, then go to DRAIN with idx=0.
REQ-015 In DRAIN, out_valid_o SHALL be 1 with out_data_o=cnt_val_i[idx], out_idx_o=idx, out_ovf_o=snapshot[idx] and out_last_o=(idx==N_CNT-1).
REQ-016 A DRAIN beat SHALL transfer only on out_valid_o && out_ready_i; outputs SHALL remain stable while valid && !ready.
REQ-017 The transfer with out_last_o=1 SHALL leave DRAIN: to IDLE if the drained save was a final save, otherwise to RUN.
REQ-018 Per channel, ovf sticky SHALL set on ovf_i in any non-IDLE cycle; on a save command cycle, snapshot SHALL equal sticky|ovf_i and sticky SHALL clear.
REQ-019 If the interval reaches 0 while in WAIT or DRAIN, the save SHALL be deferred to the first RUN cycle and overrun_o SHALL set; the reload happens at the actual save.
REQ-020 cfg_stop_i in RUN SHALL issue a final save (cmd_we=1, en=0, save=1, clear=0) instead of a periodic save, then go WAIT, DRAIN, IDLE.
REQ-021 cfg_stop_i in WAIT or DRAIN SHALL be latched; the next RUN cycle SHALL issue the final save, and this final save takes priority over any due periodic save.
REQ-022 SHALL ignore cfg_start_i outside IDLE and cfg_stop_i in IDLE.
REQ-023 cmd_we_o SHALL be high only on the command cycles above; en_o, clear_o and save_o SHALL be 0 whenever cmd_we_o=0.

Configuration
REQ-024 With PERF_MON_AUTO_CLEAR_EN defined, periodic saves SHALL also assert clear_o=1, giving per-window deltas; events coincident with that save cycle are lost because counter clear has priority.
REQ-025 Without PERF_MON_AUTO_CLEAR_EN, periodic saves SHALL assert clear_o=0, giving cumulative values since start.

Reset
REQ-026 reset_i SHALL asynchronously force IDLE, all command and stream outputs to 0, idx=0, and clear the interval counter, sticky/snapshot bits, overrun_o and the stop latch.
REQ-027 Reset mid-DRAIN SHALL drop out_valid_o immediately with no further beats.

Verification
REQ-028 Setup N_CNT=4, P=10, start at cycle 0, out_ready_i=1: save at cycle 10, beats idx 0..3 on cycles 12..15, last on idx 3.
REQ-029 Setup P=3, out_ready_i=0 for 8 cycles: overrun_o=1 and a save is issued on the first RUN cycle after drain.
REQ-030 Stop during RUN: a save with en_o=0, clear_o=0 is followed by a 4-beat drain, then IDLE and busy_o=0.
REQ-031 ovf_i[2] pulsed mid-window: only the beat with idx 2 has out_ovf_o=1; the next window shows 0.
REQ-032 cfg_period_i=0: behaves as P=1; saves are deferred every window and overrun_o=1.
REQ-033 Reset asserted during the beat with idx 1 and ready=0: out_valid_o=0 asynchronously, then after release IDLE and a start works normally.
